player_ctrl: RTL and testbench

Player-side controller for the Space Invaders core. It debounces the four push-buttons (left, right, start, shoot) and keeps the ship's column. It also runs one player bullet and counts hits. It sits between the board buttons and the game/collision logic, and feeds ship and bullet coordinates to the renderer.

---
 rtl/player_pkg.sv | 28 ++
 rtl/edge_detector_debouncer.sv | 73 +++++++
 rtl/player_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_player_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// player_pkg
// Shared widths, constants, bullet state type and a saturating counter
// helper for the Space Invaders player-side controller.
// No ports: compile-time definitions only.
package player_pkg;

  localparam int SHIP_X_W   = 5;
  localparam int BULLET_Y_W = 4;
  localparam int SCORE_W    = 8;

  // Row reported while no bullet is in flight (off-screen marker).
  localparam logic [BULLET_Y_W-1:0] BULLET_Y_IDLE = 4'd15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FLY  = 1'b1
  } bullet_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
    if (value == {SCORE_W{1'b1}}) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/edge_detector_debouncer.sv
// edge_detector_debouncer
// Synchronises one raw asynchronous push-button, filters contact bounce and
// emits a single-cycle pulse for every accepted press (filtered 0->1 edge).
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw button level, active-high, asynchronous
//   pulse  out 1  registered one-cycle pulse per accepted press
module edge_detector_debouncer #(
  parameter int DEBOUNCE_CYCLES = 360000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a_r;
  logic             sync_b_r;
  logic             level_r;
  logic             level_d_r;
  logic             pulse_r;
  logic [CNT_W-1:0] cnt_r;

  logic             level_next_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Stability filter: the level follows the synchronised input only after
  // it has disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement
  // (a bounce back) restarts the count.
  always_comb begin
    level_next_s = level_r;
    cnt_next_s   = cnt_r;
    if (sync_b_r != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_next_s = sync_b_r;
        cnt_next_s   = '0;
      end else begin
        level_next_s = level_r;
        cnt_next_s   = cnt_r + 1'b1;
      end
    end else begin
      level_next_s = level_r;
      cnt_next_s   = '0;
    end
  end

  // Synchroniser, filter state and registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_r  <= 1'b0;
      sync_b_r  <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= '0;
      pulse_r   <= 1'b0;
    end else begin
      sync_a_r  <= raw;
      sync_b_r  <= sync_a_r;
      level_r   <= level_next_s;
      level_d_r <= level_r;
      cnt_r     <= cnt_next_s;
      // Releases (1->0) never produce a pulse.
      pulse_r   <= level_r & ~level_d_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl
// Player-side controller: debounces the four buttons, keeps the ship
// column, runs the single player bullet and counts invader hits.
// Ports:
//   i_clk_36MHz        in  1  clock
//   i_reset            in  1  asynchronous active-low reset
//   i_left/i_right     in  1  raw move buttons
//   i_start/i_shoot    in  1  raw start / fire buttons
//   i_enable           in  1  game running; gates motion and firing
//   i_hit              in  1  bullet struck an invader (one-cycle pulse)
//   i_clear_score      in  1  synchronous score clear
//   o_ship_x           out 5  ship column
//   o_start_debounced  out 1  one-cycle pulse per accepted start press
//   o_bullet_x         out 5  bullet column (follows ship while idle)
//   o_bullet_y         out 4  bullet row, 15 when idle
//   o_bullet_active    out 1  bullet in flight
//   o_score            out 8  saturating hit count
module player_ctrl
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 360000,
  parameter int BULLET_STEP_CYCLES = 1800000,
  parameter int SHIP_X_MAX         = 19,
  parameter int SHIP_X_RESET       = 9,
  parameter int BULLET_Y_START     = 14
) (
  input  logic                  i_clk_36MHz,
  input  logic                  i_reset,
  input  logic                  i_left,
  input  logic                  i_right,
  input  logic                  i_start,
  input  logic                  i_shoot,
  input  logic                  i_enable,
  input  logic                  i_hit,
  input  logic                  i_clear_score,
  output logic [SHIP_X_W-1:0]   o_ship_x,
  output logic                  o_start_debounced,
  output logic [SHIP_X_W-1:0]   o_bullet_x,
  output logic [BULLET_Y_W-1:0] o_bullet_y,
  output logic                  o_bullet_active,
  output logic [SCORE_W-1:0]    o_score
);

  localparam int STEP_W = (BULLET_STEP_CYCLES > 2) ? $clog2(BULLET_STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(BULLET_STEP_CYCLES - 1);
  localparam logic [SHIP_X_W-1:0]   X_MAX     = SHIP_X_W'(SHIP_X_MAX);
  localparam logic [SHIP_X_W-1:0]   X_RESET   = SHIP_X_W'(SHIP_X_RESET);
  localparam logic [BULLET_Y_W-1:0] Y_START   = BULLET_Y_W'(BULLET_Y_START);

  logic left_p_s;
  logic right_p_s;
  logic start_p_s;
  logic shoot_p_s;

  logic [SHIP_X_W-1:0]   ship_x_r;
  logic [SHIP_X_W-1:0]   ship_x_next_s;
  bullet_state_e         state_r;
  bullet_state_e         state_next_s;
  logic [SHIP_X_W-1:0]   bullet_x_r;
  logic [SHIP_X_W-1:0]   bullet_x_next_s;
  logic [BULLET_Y_W-1:0] bullet_y_r;
  logic [BULLET_Y_W-1:0] bullet_y_next_s;
  logic [STEP_W-1:0]     step_cnt_r;
  logic [STEP_W-1:0]     step_cnt_next_s;
  logic [SCORE_W-1:0]    score_r;
  logic [SCORE_W-1:0]    score_next_s;

  edge_detector_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk   (i_clk_36MHz),
    .rst_n (i_reset),
    .raw   (i_left),
    .pulse (left_p_s)
  );

  edge_detector_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk   (i_clk_36MHz),
    .rst_n (i_reset),
    .raw   (i_right),
    .pulse (right_p_s)
  );

  edge_detector_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (i_clk_36MHz),
    .rst_n (i_reset),
    .raw   (i_start),
    .pulse (start_p_s)
  );

  edge_detector_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_shoot (
    .clk   (i_clk_36MHz),
    .rst_n (i_reset),
    .raw   (i_shoot),
    .pulse (shoot_p_s)
  );

  // Ship column: one saturating step per accepted press; simultaneous
  // left and right cancel out.
  always_comb begin
    ship_x_next_s = ship_x_r;
    if (i_enable && left_p_s && !right_p_s) begin
      if (ship_x_r != '0) begin
        ship_x_next_s = ship_x_r - 1'b1;
      end else begin
        ship_x_next_s = ship_x_r;
      end
    end else if (i_enable && right_p_s && !left_p_s) begin
      if (ship_x_r < X_MAX) begin
        ship_x_next_s = ship_x_r + 1'b1;
      end else begin
        ship_x_next_s = ship_x_r;
      end
    end else begin
      ship_x_next_s = ship_x_r;
    end
  end

  // Bullet FSM. While idle the registered column follows the ship's next
  // column so both outputs stay equal cycle for cycle.
  always_comb begin
    state_next_s    = state_r;
    bullet_x_next_s = bullet_x_r;
    bullet_y_next_s = bullet_y_r;
    step_cnt_next_s = step_cnt_r;
    case (state_r)
      IDLE: begin
        if (shoot_p_s && i_enable) begin
          state_next_s    = FLY;
          bullet_x_next_s = ship_x_r;
          bullet_y_next_s = Y_START;
          step_cnt_next_s = '0;
        end else begin
          state_next_s    = IDLE;
          bullet_x_next_s = ship_x_next_s;
          bullet_y_next_s = BULLET_Y_IDLE;
          step_cnt_next_s = '0;
        end
      end
      FLY: begin
        if (i_hit) begin
          // A hit wins over a row advance in the same cycle.
          state_next_s    = IDLE;
          bullet_x_next_s = ship_x_next_s;
          bullet_y_next_s = BULLET_Y_IDLE;
          step_cnt_next_s = '0;
        end else if (step_cnt_r == STEP_LAST) begin
          step_cnt_next_s = '0;
          if (bullet_y_r != '0) begin
            state_next_s    = FLY;
            bullet_x_next_s = bullet_x_r;
            bullet_y_next_s = bullet_y_r - 1'b1;
          end else begin
            // Bullet left the top of the screen.
            state_next_s    = IDLE;
            bullet_x_next_s = ship_x_next_s;
            bullet_y_next_s = BULLET_Y_IDLE;
          end
        end else begin
          state_next_s    = FLY;
          bullet_x_next_s = bullet_x_r;
          bullet_y_next_s = bullet_y_r;
          step_cnt_next_s = step_cnt_r + 1'b1;
        end
      end
      default: begin
        state_next_s    = IDLE;
        bullet_x_next_s = ship_x_next_s;
        bullet_y_next_s = BULLET_Y_IDLE;
        step_cnt_next_s = '0;
      end
    endcase
  end

  // Score: clear beats a hit; hits only count while a bullet is flying.
  always_comb begin
    score_next_s = score_r;
    if (i_clear_score) begin
      score_next_s = '0;
    end else if (i_hit && (state_r == FLY)) begin
      score_next_s = sat_inc(score_r);
    end else begin
      score_next_s = score_r;
    end
  end

  // State registers for ship, bullet and score.
  always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
    if (!i_reset) begin
      ship_x_r   <= X_RESET;
      state_r    <= IDLE;
      bullet_x_r <= X_RESET;
      bullet_y_r <= BULLET_Y_IDLE;
      step_cnt_r <= '0;
      score_r    <= '0;
    end else begin
      ship_x_r   <= ship_x_next_s;
      state_r    <= state_next_s;
      bullet_x_r <= bullet_x_next_s;
      bullet_y_r <= bullet_y_next_s;
      step_cnt_r <= step_cnt_next_s;
      score_r    <= score_next_s;
    end
  end

  assign o_ship_x          = ship_x_r;
  assign o_start_debounced = start_p_s;
  assign o_bullet_x        = bullet_x_r;
  assign o_bullet_y        = bullet_y_r;
  assign o_bullet_active   = (state_r == FLY);
  assign o_score           = score_r;

endmodule

// File: tb/tb_player_ctrl.sv
`timescale 1ns/1ps
module tb_player_ctrl;

  localparam int DB     = 4;
  localparam int STEP   = 3;
  localparam int XMAX   = 19;
  localparam int XRST   = 9;
  localparam int YSTART = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       left, right, start, shoot, enable, hit, clr;
  logic [4:0] ship_x, bullet_x;
  logic [3:0] bullet_y;
  logic       active, start_p;
  logic [7:0] score;

  always #5 clk = ~clk;

  player_ctrl #(
    .DEBOUNCE_CYCLES(DB), .BULLET_STEP_CYCLES(STEP), .SHIP_X_MAX(XMAX),
    .SHIP_X_RESET(XRST), .BULLET_Y_START(YSTART)
  ) dut (
    .i_clk_36MHz(clk), .i_reset(rst_n),
    .i_left(left), .i_right(right), .i_start(start), .i_shoot(shoot),
    .i_enable(enable), .i_hit(hit), .i_clear_score(clr),
    .o_ship_x(ship_x), .o_start_debounced(start_p),
    .o_bullet_x(bullet_x), .o_bullet_y(bullet_y),
    .o_bullet_active(active), .o_score(score)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Button b: raw history (index 0 = newest sample). The filter sees the raw
  // value two samples late; the accepted level flips once DB consecutive
  // seen values disagree with it. A press pulse shows one cycle after the
  // level rose.
  bit rh[4][DB+2];
  bit m_lvl[4], m_lvl_prev[4], m_pulse[4];
  int m_x, m_bx, m_by, m_score, m_cnt;
  bit m_fly;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < DB + 2; i++) rh[b][i] = 1'b0;
      m_lvl[b] = 1'b0; m_lvl_prev[b] = 1'b0; m_pulse[b] = 1'b0;
    end
    m_x = XRST; m_bx = XRST; m_by = 15; m_score = 0; m_cnt = 0; m_fly = 1'b0;
  endtask

  task automatic model_step();
    bit raw[4];
    bit p[4];
    bit all_diff;
    int old_x;
    raw[0] = left; raw[1] = right; raw[2] = start; raw[3] = shoot;
    for (int b = 0; b < 4; b++) p[b] = m_pulse[b];
    for (int b = 0; b < 4; b++) begin
      for (int i = DB + 1; i > 0; i--) rh[b][i] = rh[b][i-1];
      rh[b][0] = raw[b];
      all_diff = 1'b1;
      for (int i = 2; i < DB + 2; i++) if (rh[b][i] == m_lvl[b]) all_diff = 1'b0;
      m_pulse[b]    = m_lvl[b] & ~m_lvl_prev[b];
      m_lvl_prev[b] = m_lvl[b];
      if (all_diff) m_lvl[b] = ~m_lvl[b];
    end
    old_x = m_x;
    if (enable && p[0] && !p[1] && m_x > 0) m_x--;
    else if (enable && p[1] && !p[0] && m_x < XMAX) m_x++;
    if (clr) m_score = 0;
    else if (hit && m_fly && m_score < 255) m_score++;
    if (!m_fly) begin
      if (p[3] && enable) begin
        m_fly = 1'b1; m_bx = old_x; m_by = YSTART; m_cnt = 0;
      end
    end else if (hit) begin
      m_fly = 1'b0;
    end else begin
      m_cnt++;
      if (m_cnt == STEP) begin
        m_cnt = 0;
        if (m_by > 0) m_by--;
        else m_fly = 1'b0;
      end
    end
    if (!m_fly) begin
      m_bx = m_x; m_by = 15;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && rst_n) begin
        check("ship_x",   ship_x,   m_x);
        check("bullet_x", bullet_x, m_bx);
        check("bullet_y", bullet_y, m_by);
        check("active",   active,   m_fly);
        check("score",    score,    m_score);
        check("start_p",  start_p,  m_pulse[2]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_btn(input int b, input bit v);
    case (b)
      0: left = v;
      1: right = v;
      2: start = v;
      default: shoot = v;
    endcase
  endtask

  task automatic press(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      set_btn(b, 1'b1); repeat (7) @(negedge clk);
      set_btn(b, 1'b0); repeat (7) @(negedge clk);
    end
  endtask

  task automatic wait_active(input bit want, input int bound, input string name);
    int n = 0;
    while (active !== want && n < bound) begin @(negedge clk); n++; end
    check(name, active, want);
  endtask

  task automatic wait_y(input int y, input int bound);
    int n = 0;
    while (bullet_y != y && n < bound) begin @(negedge clk); n++; end
    check("wait_y", bullet_y, y);
  endtask

  task automatic pulse_hit(input bit with_clear);
    hit = 1'b1; clr = with_clear;
    @(negedge clk);
    hit = 1'b0; clr = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int cnt;
    rst_n = 1'b0;
    left = 0; right = 0; start = 0; shoot = 0; enable = 1; hit = 0; clr = 0;
    repeat (3) @(negedge clk);
    check("rst_ship_x", ship_x, 9);
    check("rst_bullet_y", bullet_y, 15);
    check("rst_active", active, 0);
    check("rst_score", score, 0);
    check("rst_start", start_p, 0);
    #1 rst_n = 1'b1; cmp_en = 1'b1;
    @(negedge clk);

    // Bouncy right press: one move only, release silent.
    for (int i = 0; i < 8; i++) begin
      right = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    right = 1'b1; repeat (10) @(negedge clk);
    right = 1'b0; repeat (10) @(negedge clk);
    check("bouncy_x", ship_x, 10);

    // Saturation and enable gating.
    press(1, 12); check("sat_right", ship_x, 19);
    press(0, 25); check("sat_left", ship_x, 0);
    enable = 1'b0; press(1, 3); check("disabled_x", ship_x, 0);
    enable = 1'b1; press(1, 5); check("ship_at_5", ship_x, 5);

    // Start button: one pulse per press.
    cnt = 0;
    start = 1'b1;
    for (int i = 0; i < 14; i++) begin @(negedge clk); if (start_p) cnt++; end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (start_p) cnt++; end
    check("start_pulses", cnt, 1);

    // Flight to top.
    shoot = 1'b1; wait_active(1'b1, 20, "launch"); shoot = 1'b0;
    check("launch_x", bullet_x, 5);
    check("launch_y", bullet_y, 14);
    n = 0;
    while (active && n < 100) begin @(negedge clk); n++; end
    check("flight_cycles", n, 45);
    check("flight_score", score, 0);
    check("flight_idle_y", bullet_y, 15);

    // Hit mid-flight, relaunch, shoot during flight ignored.
    repeat (8) @(negedge clk);
    shoot = 1'b1; wait_active(1'b1, 20, "launch2"); shoot = 1'b0;
    wait_y(7, 60);
    pulse_hit(1'b0);
    check("hit_active", active, 0);
    check("hit_y", bullet_y, 15);
    check("hit_score", score, 1);
    repeat (8) @(negedge clk);
    shoot = 1'b1; wait_active(1'b1, 20, "relaunch"); shoot = 1'b0;
    check("relaunch_y", bullet_y, 14);
    repeat (8) @(negedge clk);
    press(3, 1);
    check("still_flying", active, 1);
    pulse_hit(1'b0);
    check("score_2", score, 2);

    // Score control.
    repeat (8) @(negedge clk);
    pulse_hit(1'b0);
    check("idle_hit_score", score, 2);
    shoot = 1'b1; wait_active(1'b1, 20, "launch_clr"); shoot = 1'b0;
    pulse_hit(1'b1);
    check("hit_clear_score", score, 0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 260; i++) begin
      shoot = 1'b1; wait_active(1'b1, 20, "launch_sat"); shoot = 1'b0;
      pulse_hit(1'b0);
      repeat (8) @(negedge clk);
    end
    check("score_sat", score, 255);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) left  = ~left;
      if ($urandom_range(0, 7) == 0) right = ~right;
      if ($urandom_range(0, 7) == 0) start = ~start;
      if ($urandom_range(0, 5) == 0) shoot = ~shoot;
      enable = ($urandom_range(0, 15) != 0);
      hit    = ($urandom_range(0, 11) == 0);
      clr    = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    left = 0; right = 0; start = 0; shoot = 0; hit = 0; clr = 0; enable = 1;
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-flight and mid-debounce.
    shoot = 1'b1; wait_active(1'b1, 20, "launch_rst"); shoot = 1'b0;
    right = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; right = 1'b0;
    #1;
    check("arst_ship_x", ship_x, 9);
    check("arst_bullet_y", bullet_y, 15);
    check("arst_active", active, 0);
    check("arst_score", score, 0);
    check("arst_start", start_p, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_x", ship_x, 9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
